stencil_1d_reduce: RTL and testbench

Downstream consumer of the `stencil_1d` kernel: once the stencil has finished filling its 64-entry result memref, this block scans an address range of that memref through a standard HIR read port. It produces the signed sum, the maximum, the address of the first maximum and the element count, then pulses `tdone`. It sits between the stencil output buffer and the host-visible result registers, and is started by the same `tstart`-pulse convention as the kernels.

---
 rtl/stencil_1d_reduce.sv | 111 +++++++++++
 tb/tb_stencil_1d_reduce.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stencil_1d_reduce.sv
// stencil_1d_reduce: scans [lb,ub) of a memref through an HIR read port and
// reports signed sum, max, first-max address and element count.
module stencil_1d_reduce #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tstart,
  input  logic [ADDR_W-1:0]          lb,
  input  logic [ADDR_W:0]            ub,
  output logic [ADDR_W-1:0]          v0_addr,
  output logic                       v0_rd_en,
  input  logic [DATA_W-1:0]          v0_rd_data,
  output logic [DATA_W+ADDR_W:0]     sum,
  output logic [DATA_W-1:0]          max,
  output logic [ADDR_W-1:0]          max_idx,
  output logic [ADDR_W:0]            count,
  output logic                       busy,
  output logic                       tdone
);
  localparam int SW = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = 1;
  localparam logic [ADDR_W-1:0] ONE_A   = 1;
  localparam logic [DATA_W-1:0] MIN_V   = {1'b1, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr, r_vaddr, r_max_idx;
  logic [ADDR_W:0]     r_ub, r_count;
  logic                r_rd_en, r_vld, r_tdone;
  logic [SW-1:0]       r_sum;
  logic [DATA_W-1:0]   r_max;
  logic                w_empty, w_last, w_gt;
  logic [SW-1:0]       w_ext;
  assign w_empty = ({1'b0, lb} >= ub) || (ub > DEPTH_L);
  assign w_last  = ({1'b0, r_addr} + ONE_C) == r_ub;
  assign w_ext   = {{(ADDR_W+1){v0_rd_data[DATA_W-1]}}, v0_rd_data};
  assign w_gt    = $signed(v0_rd_data) > $signed(r_max);
  // r_vld/r_vaddr shadow the previous cycle's read so data and address line up
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_vaddr   <= '0;
      r_ub      <= '0;
      r_rd_en   <= 1'b0;
      r_vld     <= 1'b0;
      r_tdone   <= 1'b0;
      r_sum     <= '0;
      r_count   <= '0;
      r_max     <= MIN_V;
      r_max_idx <= '0;
    end else begin
      r_tdone <= 1'b0;
      r_vld   <= r_rd_en;
      r_vaddr <= r_addr;
      if (r_vld) begin
        r_sum   <= r_sum + w_ext;
        r_count <= r_count + ONE_C;
        if (w_gt) begin
          r_max     <= v0_rd_data;
          r_max_idx <= r_vaddr;
        end
      end
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (tstart) begin
            r_ub      <= ub;
            r_sum     <= '0;
            r_count   <= '0;
            r_max     <= MIN_V;
            r_max_idx <= '0;
            if (w_empty) begin
              r_state <= DONE;
              r_tdone <= 1'b1;
            end else begin
              r_state <= READ;
              r_rd_en <= 1'b1;
              r_addr  <= lb;
            end
          end
        end
        READ: begin
          if (w_last) begin
            r_state <= DRAIN;
            r_rd_en <= 1'b0;
            r_addr  <= '0;
          end else begin
            r_addr <= r_addr + ONE_A;
          end
        end
        DRAIN: begin
          r_state <= DONE;
          r_tdone <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign v0_addr  = r_addr;
  assign v0_rd_en = r_rd_en;
  assign sum      = r_sum;
  assign max      = r_max;
  assign max_idx  = r_max_idx;
  assign count    = r_count;
  assign busy     = r_state != IDLE;
  assign tdone    = r_tdone;
endmodule

// File: tb/tb_stencil_1d_reduce.sv
// tb_stencil_1d_reduce: directed scenarios against hand-computed results.
module tb_stencil_1d_reduce;
  logic        clk = 0;
  logic        rst = 1;
  logic        tstart = 0;
  logic [5:0]  lb = 0;
  logic [6:0]  ub = 0;
  logic [5:0]  v0_addr;
  logic        v0_rd_en;
  logic [31:0] v0_rd_data = 0;
  logic [38:0] sum;
  logic [31:0] max;
  logic [5:0]  max_idx;
  logic [6:0]  count;
  logic        busy;
  logic        tdone;
  logic [31:0] mem [64];
  int tests = 0;
  int fails = 0;
  stencil_1d_reduce dut (
    .clk(clk), .rst(rst), .tstart(tstart), .lb(lb), .ub(ub),
    .v0_addr(v0_addr), .v0_rd_en(v0_rd_en), .v0_rd_data(v0_rd_data),
    .sum(sum), .max(max), .max_idx(max_idx), .count(count),
    .busy(busy), .tdone(tdone)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (v0_rd_en) v0_rd_data <= mem[v0_addr];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // pulses tstart, then records read window, address errors and tdone cycle
  task automatic run(input logic [5:0] l, input logic [6:0] u,
                     output int f, output int ls, output int n, output int d, output int aerr);
    f = -1; ls = -1; n = 0; d = -1; aerr = 0;
    lb = l; ub = u; tstart = 1;
    tick;
    tstart = 0;
    for (int k = 1; k < 200 && d < 0; k++) begin
      if (v0_rd_en) begin
        if (f < 0) f = k;
        ls = k;
        n++;
        if (v0_addr !== 6'(int'(l) + k - 1)) aerr++;
      end else if (v0_addr !== 6'd0) aerr++;
      if (tdone) d = k;
      if (d < 0) tick;
    end
    tick;
  endtask
  task automatic test_reset;
    rst = 1;
    tick; tick;
    tests++; if (sum !== 39'd0) begin fails++; $display("FAIL reset_sum got %0d exp 0", sum); end
    tests++; if (max !== 32'h80000000) begin fails++; $display("FAIL reset_max got %h exp 80000000", max); end
    tests++; if ({max_idx, count, busy, tdone, v0_rd_en, v0_addr} !== 21'd0) begin fails++; $display("FAIL reset_ctrl got %h exp 0", {max_idx, count, busy, tdone, v0_rd_en, v0_addr}); end
    lb = 0; ub = 4; tstart = 1;
    tick;
    tstart = 0;
    tests++; if (busy !== 1'b0 || v0_rd_en !== 1'b0) begin fails++; $display("FAIL reset_prio busy %b rd_en %b exp 0 0", busy, v0_rd_en); end
    rst = 0;
    tick;
  endtask
  task automatic test_full;
    int f, ls, n, d, ae;
    for (int i = 0; i < 64; i++) mem[i] = i;
    run(0, 64, f, ls, n, d, ae);
    tests++; if (f !== 1 || ls !== 64 || n !== 64) begin fails++; $display("FAIL full_rd got %0d..%0d n=%0d exp 1..64 n=64", f, ls, n); end
    tests++; if (d !== 66) begin fails++; $display("FAIL full_tdone got %0d exp 66", d); end
    tests++; if (ae !== 0) begin fails++; $display("FAIL full_addr got %0d errors exp 0", ae); end
    tests++; if (sum !== 39'd2016) begin fails++; $display("FAIL full_sum got %0d exp 2016", $signed(sum)); end
    tests++; if (max !== 32'd63 || max_idx !== 6'd63) begin fails++; $display("FAIL full_max got %0d@%0d exp 63@63", max, max_idx); end
    tests++; if (count !== 7'd64) begin fails++; $display("FAIL full_count got %0d exp 64", count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy got %b exp 0", busy); end
  endtask
  task automatic test_stencil;
    int f, ls, n, d, ae;
    for (int i = 0; i < 64; i++) mem[i] = -i;
    mem[10] = 500;
    run(1, 64, f, ls, n, d, ae);
    tests++; if (d !== 65 || ae !== 0) begin fails++; $display("FAIL sten_tdone got %0d aerr %0d exp 65 0", d, ae); end
    tests++; if (sum !== -39'sd1506) begin fails++; $display("FAIL sten_sum got %0d exp -1506", $signed(sum)); end
    tests++; if (max !== 32'd500 || max_idx !== 6'd10) begin fails++; $display("FAIL sten_max got %0d@%0d exp 500@10", $signed(max), max_idx); end
    tests++; if (count !== 7'd63) begin fails++; $display("FAIL sten_count got %0d exp 63", count); end
  endtask
  task automatic test_ties_empty;
    int f, ls, n, d, ae;
    for (int i = 0; i < 64; i++) mem[i] = 7;
    run(3, 8, f, ls, n, d, ae);
    tests++; if (max !== 32'd7 || max_idx !== 6'd3) begin fails++; $display("FAIL tie_max got %0d@%0d exp 7@3", max, max_idx); end
    tests++; if (sum !== 39'd35 || count !== 7'd5 || d !== 7) begin fails++; $display("FAIL tie_sum got %0d cnt %0d d %0d exp 35 5 7", sum, count, d); end
    run(5, 5, f, ls, n, d, ae);
    tests++; if (d !== 1 || n !== 0) begin fails++; $display("FAIL empty_eq got d=%0d n=%0d exp 1 0", d, n); end
    tests++; if (sum !== 39'd0 || count !== 7'd0 || max !== 32'h80000000 || max_idx !== 6'd0) begin fails++; $display("FAIL empty_eq_res got %0d %0d %h %0d exp 0 0 80000000 0", sum, count, max, max_idx); end
    run(0, 8, f, ls, n, d, ae);
    run(0, 65, f, ls, n, d, ae);
    tests++; if (d !== 1 || n !== 0) begin fails++; $display("FAIL empty_ub65 got d=%0d n=%0d exp 1 0", d, n); end
    tests++; if (sum !== 39'd0 || count !== 7'd0 || max !== 32'h80000000) begin fails++; $display("FAIL empty_ub65_res got %0d %0d %h exp 0 0 80000000", sum, count, max); end
    run(9, 4, f, ls, n, d, ae);
    tests++; if (d !== 1 || n !== 0) begin fails++; $display("FAIL empty_inv got d=%0d n=%0d exp 1 0", d, n); end
  endtask
  task automatic test_extremes;
    int f, ls, n, d, ae;
    for (int i = 0; i < 64; i++) mem[i] = 32'h7FFFFFFF;
    run(0, 64, f, ls, n, d, ae);
    tests++; if (sum !== 39'sd137438953408) begin fails++; $display("FAIL ext_pos_sum got %0d exp 137438953408", $signed(sum)); end
    tests++; if (max !== 32'h7FFFFFFF || max_idx !== 6'd0) begin fails++; $display("FAIL ext_pos_max got %h@%0d exp 7fffffff@0", max, max_idx); end
    for (int i = 0; i < 64; i++) mem[i] = 32'h80000000;
    run(0, 64, f, ls, n, d, ae);
    tests++; if (sum !== -39'sd137438953472) begin fails++; $display("FAIL ext_neg_sum got %0d exp -137438953472", $signed(sum)); end
    tests++; if (max !== 32'h80000000 || max_idx !== 6'd0 || count !== 7'd64) begin fails++; $display("FAIL ext_neg_max got %h@%0d cnt %0d exp 80000000@0 64", max, max_idx, count); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] rdm, dm;
    rdm = 0; dm = 0;
    for (int i = 0; i < 64; i++) mem[i] = i;
    lb = 2; ub = 12; tstart = 1;
    tick;
    for (int k = 1; k <= 30; k++) begin
      rdm[k] = v0_rd_en;
      dm[k] = tdone;
      if (k == 12) begin
        tests++; if (sum !== 39'd65 || count !== 7'd10 || max !== 32'd11 || max_idx !== 6'd11) begin fails++; $display("FAIL b2b_first got %0d %0d %0d@%0d exp 65 10 11@11", sum, count, max, max_idx); end
      end
      tstart = (k == 3 || k == 12);
      lb = (k == 3) ? 6'd40 : 6'd0;
      ub = (k == 3) ? 7'd50 : 7'd2;
      tick;
    end
    tstart = 0;
    tests++; if (rdm !== 32'h000067FE) begin fails++; $display("FAIL b2b_reads got %h exp 000067fe", rdm); end
    tests++; if (dm !== 32'h00011000) begin fails++; $display("FAIL b2b_tdone got %h exp 00011000", dm); end
    tests++; if (sum !== 39'd1 || count !== 7'd2 || max !== 32'd1 || max_idx !== 6'd1) begin fails++; $display("FAIL b2b_second got %0d %0d %0d@%0d exp 1 2 1@1", sum, count, max, max_idx); end
  endtask
  task automatic test_mid_reset;
    int f, ls, n, d, ae, dn;
    dn = 0;
    lb = 0; ub = 20; tstart = 1;
    tick;
    tstart = 0;
    for (int k = 1; k <= 30; k++) begin
      if (tdone) dn++;
      if (k == 6) begin
        tests++; if (v0_rd_en !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mrst_ctrl rd_en %b busy %b exp 0 0", v0_rd_en, busy); end
        tests++; if (sum !== 39'd0 || count !== 7'd0 || max !== 32'h80000000 || max_idx !== 6'd0) begin fails++; $display("FAIL mrst_res got %0d %0d %h %0d exp 0 0 80000000 0", sum, count, max, max_idx); end
      end
      rst = (k == 5);
      tick;
    end
    rst = 0;
    tests++; if (dn !== 0) begin fails++; $display("FAIL mrst_tdone got %0d pulses exp 0", dn); end
    run(0, 4, f, ls, n, d, ae);
    tests++; if (d !== 6 || sum !== 39'd6 || count !== 7'd4) begin fails++; $display("FAIL mrst_after got d=%0d %0d %0d exp 6 6 4", d, sum, count); end
  endtask
  initial begin
    test_reset;
    test_full;
    test_stencil;
    test_ties_empty;
    test_extremes;
    test_back_to_back;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
